// File: rtl/card_shoe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_shoe_pkg
// Description : Shared types and constants for the card shoe. Holds the
//               dealer state encoding, the rank count, the LFSR tap mask and
//               the rank-to-card-value mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package card_shoe_pkg;

    localparam int          NUM_RANKS = 13;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (state bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHUFFLE = 3'd1,
        ST_PICK    = 3'd2,
        ST_PROBE   = 3'd3,
        ST_DEAL    = 3'd4
    } state_t;

    // Ace counts as 1 here; ace-as-11 is left to the consumer.
    function automatic logic [4:0] rank_value(input logic [3:0] rank);
        logic [4:0] v;
        if (rank == 4'd0) begin
            v = 5'd1;
        end else if (rank <= 4'd9) begin
            v = {1'b0, rank} + 5'd1;
        end else begin
            v = 5'd10;
        end
        return v;
    endfunction

endpackage : card_shoe_pkg
`default_nettype wire

// File: rtl/card_shoe_if.sv
`default_nettype none
// ============================================================================
// Module      : card_shoe_if
// Description : Request/response bundle between the card shoe and its
//               consumer.
//               Requests  : draw_p, draw_d, shuffle (consumer -> shoe)
//               Responses : pcard, dcard, pvalid, dvalid, busy,
//                           cards_left, shuffled  (shoe -> consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface card_shoe_if;
    logic       draw_p;
    logic       draw_d;
    logic       shuffle;
    logic [4:0] pcard;
    logic [4:0] dcard;
    logic       pvalid;
    logic       dvalid;
    logic       busy;
    logic [7:0] cards_left;
    logic       shuffled;

    modport master (
        output draw_p, draw_d, shuffle,
        input  pcard, dcard, pvalid, dvalid, busy, cards_left, shuffled
    );

    modport slave (
        input  draw_p, draw_d, shuffle,
        output pcard, dcard, pvalid, dvalid, busy, cards_left, shuffled
    );
endinterface : card_shoe_if
`default_nettype wire

// File: rtl/card_shoe_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, loaded with SEED on reset
//               and advanced every clock. Only the low nibble is exported as
//               that is all the shoe needs to pick a rank.
//               Ports: clk, rst (async, active-high), o_low4 (state[3:0])
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import card_shoe_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    output logic [3:0]      o_low4
);

    // An all-zero state would lock up the register.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_low4 = lfsr_q[3:0];

endmodule : lfsr16
`default_nettype wire

// File: rtl/card_shoe.sv
`default_nettype none
// ============================================================================
// Module      : card_shoe
// Description : Finite shoe of DECKS 52-card decks dealing pseudo-random
//               cards without replacement to a player and a dealer seat.
//               Reshuffles on request or when a draw finds the shoe empty.
//               Ports: Clock, reset (async, active-high),
//                      bus (card_shoe_if.slave: draw_p/draw_d/shuffle in;
//                      pcard/dcard/pvalid/dvalid/busy/cards_left/shuffled out)
// Revision    : 1.0 - initial release
// ============================================================================
module card_shoe
    import card_shoe_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          DECKS     = 1
) (
    input  wire logic      Clock,
    input  wire logic      reset,
    card_shoe_if.slave     bus
);

    localparam logic [3:0] RANK_FULL = 4'(4 * DECKS);
    localparam logic [7:0] SHOE_FULL = 8'(52 * DECKS);
    localparam logic [3:0] LAST_RANK = 4'(NUM_RANKS - 1);

    state_t     state_q, state_d;
    logic [3:0] count_q [NUM_RANKS];
    logic [3:0] count_d [NUM_RANKS];
    logic [7:0] cards_left_q, cards_left_d;
    logic [3:0] rank_q, rank_d;          // also the reload index during SHUFFLE
    logic       target_q, target_d;      // 0 = player, 1 = dealer
    logic       pend_p_q, pend_p_d;
    logic       pend_d_q, pend_d_d;
    logic       pend_s_q, pend_s_d;
    logic [4:0] pcard_q, pcard_d;
    logic [4:0] dcard_q, dcard_d;
    logic       pvalid_q, pvalid_d;
    logic       dvalid_q, dvalid_d;
    logic       busy_q, busy_d;
    logic       shuffled_q, shuffled_d;

    logic [3:0] w_lfsr_lo;
    logic       w_pend_p;
    logic       w_pend_d;
    logic       w_pend_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (Clock),
        .rst    (reset),
        .o_low4 (w_lfsr_lo)
    );

    // Arbitration sees this cycle's request as well as the latched ones, so a
    // request arriving while IDLE is acted on immediately.
    assign w_pend_p = pend_p_q | bus.draw_p;
    assign w_pend_d = pend_d_q | bus.draw_d;
    assign w_pend_s = pend_s_q | bus.shuffle;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        cards_left_d = cards_left_q;
        rank_d       = rank_q;
        target_d     = target_q;
        pend_p_d     = w_pend_p;
        pend_d_d     = w_pend_d;
        pend_s_d     = w_pend_s;
        pcard_d      = pcard_q;
        dcard_d      = dcard_q;
        pvalid_d     = 1'b0;
        dvalid_d     = 1'b0;
        shuffled_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_pend_s || ((w_pend_p || w_pend_d) && (cards_left_q == 8'd0))) begin
                    state_d = ST_SHUFFLE;
                    rank_d  = 4'd0;
                end else if (w_pend_p) begin
                    state_d  = ST_PICK;
                    target_d = 1'b0;
                end else if (w_pend_d) begin
                    state_d  = ST_PICK;
                    target_d = 1'b1;
                end
            end
            ST_SHUFFLE: begin
                count_d[rank_q] = RANK_FULL;
                if (rank_q == LAST_RANK) begin
                    cards_left_d = SHOE_FULL;
                    shuffled_d   = 1'b1;
                    // A new shuffle pulse in this very cycle is kept pending.
                    pend_s_d     = bus.shuffle;
                    state_d      = ST_IDLE;
                end else begin
                    rank_d = rank_q + 4'd1;
                end
            end
            ST_PICK: begin
                rank_d  = (w_lfsr_lo >= 4'd13) ? (w_lfsr_lo - 4'd13) : w_lfsr_lo;
                state_d = ST_PROBE;
            end
            ST_PROBE: begin
                // Linear probe terminates: cards_left > 0 guarantees a hit.
                if (count_q[rank_q] != 4'd0) begin
                    state_d = ST_DEAL;
                end else begin
                    rank_d = (rank_q == LAST_RANK) ? 4'd0 : (rank_q + 4'd1);
                end
            end
            ST_DEAL: begin
                count_d[rank_q] = count_q[rank_q] - 4'd1;
                cards_left_d    = cards_left_q - 8'd1;
                if (target_q) begin
                    dcard_d  = rank_value(rank_q);
                    dvalid_d = 1'b1;
                    pend_d_d = bus.draw_d;
                end else begin
                    pcard_d  = rank_value(rank_q);
                    pvalid_d = 1'b1;
                    pend_p_d = bus.draw_p;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NUM_RANKS; i++) begin
                count_q[i] <= RANK_FULL;
            end
            cards_left_q <= SHOE_FULL;
            rank_q       <= 4'd0;
            target_q     <= 1'b0;
            pend_p_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            pend_s_q     <= 1'b0;
            pcard_q      <= 5'd0;
            dcard_q      <= 5'd0;
            pvalid_q     <= 1'b0;
            dvalid_q     <= 1'b0;
            busy_q       <= 1'b0;
            shuffled_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            cards_left_q <= cards_left_d;
            rank_q       <= rank_d;
            target_q     <= target_d;
            pend_p_q     <= pend_p_d;
            pend_d_q     <= pend_d_d;
            pend_s_q     <= pend_s_d;
            pcard_q      <= pcard_d;
            dcard_q      <= dcard_d;
            pvalid_q     <= pvalid_d;
            dvalid_q     <= dvalid_d;
            busy_q       <= busy_d;
            shuffled_q   <= shuffled_d;
        end
    end

    assign bus.pcard      = pcard_q;
    assign bus.dcard      = dcard_q;
    assign bus.pvalid     = pvalid_q;
    assign bus.dvalid     = dvalid_q;
    assign bus.busy       = busy_q;
    assign bus.cards_left = cards_left_q;
    assign bus.shuffled   = shuffled_q;

endmodule : card_shoe
`default_nettype wire

// File: tb/tb_card_shoe.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_shoe
// Description : Directed self-checking bench for card_shoe (DECKS=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_shoe;

    logic Clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    card_shoe_if bus ();

    card_shoe #(
        .LFSR_SEED (16'hACE1),
        .DECKS     (1)
    ) dut (
        .Clock (Clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting toward the MSB.
    logic [15:0] m_lfsr;
    always @(posedge Clock or posedge reset) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int mcnt [13];
    int hist [32];

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called right after a draw is raised at a negedge. lat counts posedges
    // from the request sample up to the one that raised the valid.
    task automatic wait_valid(input bit dealer, input int maxc, output int lat,
                              output int nshuf, output logic [15:0] pick_l);
        bit seen;
        seen = 1'b0; lat = 0; nshuf = 0; pick_l = 16'h0;
        while (!seen && lat < maxc) begin
            @(negedge Clock);
            lat++;
            bus.draw_p = 1'b0;
            bus.draw_d = 1'b0;
            if (lat == 1) pick_l = m_lfsr;
            if (bus.shuffled) nshuf++;
            if (dealer ? bus.dvalid : bus.pvalid) seen = 1'b1;
        end
        check("valid_timeout", int'(seen), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cards_left"}, bus.cards_left, 52);
        check({tag, "_pcard"}, bus.pcard, 0);
        check({tag, "_dcard"}, bus.dcard, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_pulses"}, {bus.pvalid, bus.dvalid, bus.shuffled}, 0);
    endtask

    initial begin
        int lat, ns, probes, ev, sum, r;
        int p_at, d_at, np, nd, s_at, base;
        logic [15:0] pl;

        bus.draw_p = 1'b0; bus.draw_d = 1'b0; bus.shuffle = 1'b0;
        for (int i = 0; i < 13; i++) mcnt[i] = 4;
        for (int i = 0; i < 32; i++) hist[i] = 0;

        // 1. Reset values, during and after reset
        repeat (3) @(negedge Clock);
        check_reset_vals("rst_held");
        reset = 1'b0;
        @(negedge Clock);
        check_reset_vals("rst_released");

        // 2. Deal the whole shoe to the player; reference model predicts
        //    each value and latency from the LFSR state seen in PICK.
        sum = 0;
        for (int i = 0; i < 52; i++) begin
            bus.draw_p = 1'b1;
            wait_valid(1'b0, 40, lat, ns, pl);
            r = int'(pl[3:0]);
            if (r >= 13) r -= 13;
            probes = 1;
            while (mcnt[r] == 0 && probes < 14) begin
                r = (r == 12) ? 0 : r + 1;
                probes++;
            end
            mcnt[r]--;
            ev = (r == 0) ? 1 : ((r <= 9) ? r + 1 : 10);
            check("deal_value", bus.pcard, ev);
            check("deal_latency", lat, 3 + probes);
            check("deal_lat_range", int'(lat >= 4 && lat <= 16), 1);
            hist[bus.pcard]++;
            sum += int'(bus.pcard);
        end
        check("hist_1", hist[1], 4);
        for (int v = 2; v <= 9; v++) check("hist_2to9", hist[v], 4);
        check("hist_10", hist[10], 16);
        check("value_sum", sum, 340);
        check("empty_cards_left", bus.cards_left, 0);
        @(negedge Clock);
        check("empty_busy", bus.busy, 0);

        // 3. Draw from an empty shoe: auto-refill, then deal
        bus.draw_p = 1'b1;
        wait_valid(1'b0, 60, lat, ns, pl);
        check("refill_shuffled_once", ns, 1);
        check("refill_lat_range", int'(lat >= 18 && lat <= 30), 1);
        check("refill_cards_left", bus.cards_left, 51);
        check("refill_value_range", int'(bus.pcard >= 1 && bus.pcard <= 10), 1);

        // 4. Simultaneous player and dealer requests
        @(negedge Clock);
        bus.draw_p = 1'b1; bus.draw_d = 1'b1;
        p_at = -1; d_at = -1; np = 0; nd = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clock);
            bus.draw_p = 1'b0; bus.draw_d = 1'b0;
            if (bus.pvalid) begin np++; if (p_at < 0) p_at = k; end
            if (bus.dvalid) begin nd++; if (d_at < 0) d_at = k; end
        end
        check("both_pvalid_count", np, 1);
        check("both_dvalid_count", nd, 1);
        check("both_order", int'(p_at > 0 && d_at > p_at), 1);
        check("both_cards_left", bus.cards_left, 49);
        check("both_dcard_range", int'(bus.dcard >= 1 && bus.dcard <= 10), 1);

        // 5. Shuffle request during PROBE
        base = int'(bus.cards_left);
        bus.draw_p = 1'b1;
        @(negedge Clock);                 // PICK
        bus.draw_p = 1'b0;
        @(negedge Clock);                 // PROBE
        check("probe_busy", bus.busy, 1);
        bus.shuffle = 1'b1;
        p_at = -1; s_at = -1; np = 0; ns = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge Clock);
            bus.shuffle = 1'b0;
            if (bus.pvalid) begin
                np++;
                if (p_at < 0) begin
                    p_at = k;
                    check("probe_deal_cards_left", bus.cards_left, base - 1);
                end
            end
            if (bus.shuffled) begin ns++; if (s_at < 0) s_at = k; end
        end
        check("probe_pvalid_count", np, 1);
        check("probe_shuffled_count", ns, 1);
        check("probe_refill_gap", s_at - p_at, 14);
        check("probe_refilled", bus.cards_left, 52);

        // 6a. Reset during SHUFFLE (after one deal so values are non-default)
        bus.draw_p = 1'b1;
        wait_valid(1'b0, 40, lat, ns, pl);
        check("pre_rst_cards_left", bus.cards_left, 51);
        @(negedge Clock);
        bus.shuffle = 1'b1;
        @(negedge Clock);
        bus.shuffle = 1'b0;
        repeat (4) @(negedge Clock);
        check("shuffle_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_in_shuffle");
        @(negedge Clock);
        reset = 1'b0;
        np = 0; ns = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clock);
            if (bus.pvalid || bus.dvalid) np++;
            if (bus.shuffled || bus.busy) ns++;
        end
        check("post_rst_shuffle_no_valid", np, 0);
        check("post_rst_shuffle_idle", ns, 0);

        // 6b. Reset during PROBE
        bus.draw_p = 1'b1;
        wait_valid(1'b0, 40, lat, ns, pl);
        check("pre_rst2_cards_left", bus.cards_left, 51);
        @(negedge Clock);
        bus.draw_p = 1'b1;
        @(negedge Clock);                 // PICK
        bus.draw_p = 1'b0;
        @(negedge Clock);                 // PROBE
        check("probe2_busy", bus.busy, 1);
        reset = 1'b1;
        #1;
        check_reset_vals("rst_in_probe");
        @(negedge Clock);
        reset = 1'b0;
        np = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge Clock);
            if (bus.pvalid || bus.dvalid || bus.shuffled) np++;
        end
        check("post_rst_probe_no_pulse", np, 0);
        check("post_rst_probe_cards_left", bus.cards_left, 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_card_shoe
`default_nettype wire

// File: doc/card_shoe.md
Name: card_shoe

Overview:
- Upstream card source for the blackjack FSM.
- Holds a finite shoe of DECKS standard 52-card decks and deals pseudo-random cards without replacement.
- Presents per-seat card values on pcard/dcard; these feed the FSM's prandnumwire/drandnumwire inputs.
- Reshuffles automatically when the shoe is exhausted.

Parameters:
- LFSR_SEED, 16'hACE1, initial LFSR state; a value of 0 is replaced by 16'h0001.
- DECKS, 1, number of decks in the shoe; legal range 1..3, so a per-rank count of 4*DECKS fits 4 bits.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- draw_p  in  1  request one card for the player; a level sampled every cycle.
- draw_d  in  1  request one card for the dealer; a level sampled every cycle.
- shuffle  in  1  one-cycle pulse; refills the shoe before the next deal.
- pcard  out  5  value of the last card dealt to the player (1..10).
- dcard  out  5  value of the last card dealt to the dealer (1..10).
- pvalid  out  1  one-cycle pulse when pcard updates.
- dvalid  out  1  one-cycle pulse when dcard updates.
- busy  out  1  high in any state other than IDLE.
- cards_left  out  8  number of cards remaining in the shoe.
- shuffled  out  1  one-cycle pulse when a refill completes.

Behaviour:
- Reset values:
  - pcard = dcard = 0.
  - pvalid, dvalid, busy, shuffled = 0.
  - cards_left = 52*DECKS.
  - All 13 rank counts = 4*DECKS.
  - lfsr = LFSR_SEED; pending flags cleared; state = IDLE.
- Reset asserted mid-operation aborts any deal or shuffle and returns everything to the reset values.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle, regardless of state.
- Request capture:
  - Each cycle, draw_p=1 sets pend_p and draw_d=1 sets pend_d; shuffle=1 sets pend_s.
  - A pending flag clears only when its request is served.
  - Holding draw_p high for N cycles therefore yields one card plus one more card per re-assertion after it is served, not N cards.
  - The consumer pulses draw_p/draw_d for one cycle.
- Arbitration in IDLE, in priority order:
  1. pend_s, or any draw pending while cards_left==0 -> SHUFFLE.
  2. pend_p -> PICK, with target = player.
  3. pend_d -> PICK, with target = dealer.
- If draw_p and draw_d arrive in the same cycle, the player is served first and the dealer immediately after.
- States:
  - IDLE: busy=0.
  - SHUFFLE: one rank reloaded per cycle, rank index 0..12 (13 cycles). Then set cards_left = 52*DECKS, pulse shuffled, clear pend_s, and return to IDLE.
  - PICK (1 cycle): rank = lfsr[3:0]; if this is >=13, subtract 13.
  - PROBE: if count[rank]!=0 -> DEAL; otherwise rank = rank+1 (12 wraps to 0) and stay in PROBE. At most 13 PROBE cycles, and DEAL is guaranteed because cards_left>0.
  - DEAL (1 cycle):
    - count[rank] decrements by 1 and cards_left decrements by 1.
    - The target register is written.
    - The matching valid pulses in the following cycle, aligned with the new register value.
    - The served pending flag clears; next state is IDLE.
- Card value mapping:
  - rank 0 (ace) -> 1.
  - ranks 1..9 -> rank+1.
  - ranks 10..12 -> 10.
  - Ace-as-11 is the consumer's job.
- Latency from a request seen in IDLE to the valid pulse: 1 (PICK) + 1..13 (PROBE) + 1 (DEAL) + 1 cycle, i.e. 4..16 cycles. Add 14 cycles if a shuffle precedes the deal.
- shuffle asserted while busy is held in pend_s and served at the next IDLE; it never corrupts an in-flight deal.
- pcard/dcard hold their value until the next deal to the same seat.

Decomposition:
- Shared package:
  - state encoding (IDLE, SHUFFLE, PICK, PROBE, DEAL);
  - constant NUM_RANKS=13;
  - the rank-to-value mapping function;
  - the LFSR tap constant.
- One natural sub-module: lfsr16, a free-running LFSR with seed load on reset.

Test Plan:
1. Reset with DECKS=1 -> cards_left=52, pcard=dcard=0, busy=0, all pulses low.
2. 52 single-cycle draw_p pulses, each issued after the previous pvalid:
   - value histogram is 1:4, 2..9:4 each, 10:16;
   - the sum of values is 340; cards_left reaches 0;
   - every request-to-pvalid latency lies in 4..16 cycles.
3. 53rd draw_p -> shuffled pulses exactly once before pvalid; cards_left=51 afterwards; request-to-pvalid latency lies in 18..30 cycles.
4. draw_p and draw_d asserted in the same cycle -> pvalid precedes dvalid; each pulses exactly once; cards_left drops by 2.
5. shuffle pulsed while a deal is in PROBE -> the in-flight deal completes, then a 13-cycle refill runs and cards_left returns to 52.
6. reset asserted during SHUFFLE and again during PROBE -> outputs return to reset values the same cycle; no valid pulse follows.
